// File: rtl/cell_stream_reader_pkg.sv
// cell_stream_reader_pkg: FSM encoding and cell memory layout shared by the reader files
package cell_stream_reader_pkg;
    typedef enum logic [2:0] {IDLE, RD_CNT, WAIT_CNT, STREAM, DRAIN, DONE} state_t;
    localparam int CELL_COUNT_ADDR = 0;
    localparam int FIRST_PARTICLE_ADDR = 1;
    localparam int CELL_RD_LATENCY = 2;
endpackage

// File: rtl/cell_stream_reader_if.sv
// cell_stream_reader_if: valid/ready particle stream from the reader to the pair-generation front end
interface cell_stream_reader_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [ADDR_WIDTH-1:0] id;
    logic last;
    logic valid;
    logic ready;
    modport master (output data, id, last, valid, input ready);
    modport slave (input data, id, last, valid, output ready);
endinterface

// File: rtl/cell_rd_fifo.sv
// cell_rd_fifo: synchronous output FIFO with occupancy count; caller guarantees no overflow/underflow
module cell_rd_fifo import cell_stream_reader_pkg::*; #(
    parameter int WIDTH = 105,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wptr, rptr;
    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) mem[wptr] <= din;
            wptr <= wptr + PW'(push);
            rptr <= rptr + PW'(pop);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
    assign dout = mem[rptr];
endmodule

// File: rtl/cell_stream_reader.sv
// cell_stream_reader: streams a cell's particles from a 2-cycle RAM; CELL_READER_BOUNDS_CHECK_EN clamps the count
module cell_stream_reader import cell_stream_reader_pkg::*; #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_WIDTH-1:0]  particle_count,
    output logic                   count_err,
    output logic [ADDR_WIDTH-1:0]  cell_address,
    output logic                   cell_rden,
    output logic                   cell_wren,
    output logic [DATA_WIDTH-1:0]  cell_data,
    input  logic [DATA_WIDTH-1:0]  cell_q,
    cell_stream_reader_if.master   stream
);
    localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 2;
    if (PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_depth_chk
        $error("PARTICLE_NUM does not fit in ADDR_WIDTH");
    end
    state_t state, state_n;
    logic wait_ph, fetched, issue, iss_last, rd_part, rd_last, pop;
    logic [ADDR_WIDTH-1:0] next_addr, iss_addr, raw_count, cnt_val, limit;
    logic trk_v [CELL_RD_LATENCY];
    logic [ADDR_WIDTH-1:0] trk_a [CELL_RD_LATENCY];
    logic trk_l [CELL_RD_LATENCY];
    logic [CW-1:0] outstanding;
    logic [$clog2(FIFO_DEPTH):0] fcount;
    logic [FW-1:0] fdout;
    assign raw_count = cell_q[ADDR_WIDTH-1:0];
`ifdef CELL_READER_BOUNDS_CHECK_EN
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    assign cnt_val = (raw_count > MAX_COUNT) ? MAX_COUNT : raw_count;
    always_ff @(posedge clk) begin
        if (!rst || (state == IDLE && start)) count_err <= 1'b0;
        else if (fetched && raw_count > MAX_COUNT) count_err <= 1'b1;
    end
`else
    assign cnt_val = raw_count;
    assign count_err = 1'b0;
`endif
    assign pop = stream.valid && stream.ready;
    assign fetched = state == WAIT_CNT && wait_ph;
    assign iss_addr = fetched ? ADDR_WIDTH'(FIRST_PARTICLE_ADDR) : next_addr;
    // particle_count is not latched yet on the fetch cycle, so compare against the live count
    assign limit = fetched ? cnt_val : particle_count;
    assign iss_last = iss_addr == limit;
    // every read in flight or buffered holds a FIFO slot; a pop this cycle frees one
    always_comb begin
        outstanding = CW'(rd_part) + CW'(fcount);
        for (int i = 0; i < CELL_RD_LATENCY; i++) outstanding = outstanding + CW'(trk_v[i]);
        outstanding = outstanding - CW'(pop);
    end
    always_comb begin
        state_n = state;
        issue = 1'b0;
        case (state)
            IDLE:     state_n = start ? RD_CNT : IDLE;
            RD_CNT:   state_n = WAIT_CNT;
            WAIT_CNT: if (wait_ph) begin
                issue = cnt_val != '0;
                state_n = !issue ? DONE : iss_last ? DRAIN : STREAM;
            end
            STREAM: begin
                issue = outstanding < CW'(FIFO_DEPTH);
                state_n = (issue && iss_last) ? DRAIN : STREAM;
            end
            DRAIN:    state_n = (pop && stream.last) ? DONE : DRAIN;
            DONE:     state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            wait_ph <= 1'b0;
            next_addr <= '0;
            particle_count <= '0;
            cell_rden <= 1'b0;
            cell_address <= '0;
            rd_part <= 1'b0;
            rd_last <= 1'b0;
            for (int i = 0; i < CELL_RD_LATENCY; i++) begin
                trk_v[i] <= 1'b0;
                trk_a[i] <= '0;
                trk_l[i] <= 1'b0;
            end
        end else begin
            state <= state_n;
            wait_ph <= state == WAIT_CNT && !wait_ph;
            if (fetched) particle_count <= cnt_val;
            if (issue) next_addr <= iss_addr + 1'b1;
            cell_rden <= issue || (state == IDLE && start);
            cell_address <= issue ? iss_addr : ADDR_WIDTH'(CELL_COUNT_ADDR);
            rd_part <= issue;
            rd_last <= issue && iss_last;
            trk_v[0] <= rd_part;
            trk_a[0] <= cell_address;
            trk_l[0] <= rd_last;
            for (int i = 1; i < CELL_RD_LATENCY; i++) begin
                trk_v[i] <= trk_v[i-1];
                trk_a[i] <= trk_a[i-1];
                trk_l[i] <= trk_l[i-1];
            end
        end
    end
    cell_rd_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (trk_v[CELL_RD_LATENCY-1]),
        .din   ({cell_q, trk_a[CELL_RD_LATENCY-1], trk_l[CELL_RD_LATENCY-1]}),
        .pop   (pop),
        .dout  (fdout),
        .count (fcount)
    );
    assign stream.data = fdout[FW-1 -: DATA_WIDTH];
    assign stream.id = fdout[ADDR_WIDTH:1];
    assign stream.last = fdout[0];
    assign stream.valid = fcount != '0;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign cell_wren = 1'b0;
    assign cell_data = '0;
endmodule

// File: tb/tb_cell_stream_reader.sv
// tb_cell_stream_reader: scoreboard bench for cell_stream_reader with a 2-cycle memory model
module tb_cell_stream_reader;
    localparam int DW = 96, AW = 8, PN = 220, FD = 4;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic busy, done, count_err, cell_rden, cell_wren;
    logic [AW-1:0] particle_count, cell_address;
    logic [DW-1:0] cell_data;
    logic [DW-1:0] cell_q = '0, rd1 = '0;
    logic [DW-1:0] mem [256];
    typedef struct packed {
        logic [AW-1:0] id;
        logic [DW-1:0] data;
        logic last;
    } exp_t;
    exp_t sb [$];
    exp_t e;
    int passed = 0, total = 0, done_cnt = 0, outst = 0, max_outst = 0, last_id = 0;
    cell_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) sif ();
    cell_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARTICLE_NUM(PN), .FIFO_DEPTH(FD)) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .particle_count (particle_count),
        .count_err      (count_err),
        .cell_address   (cell_address),
        .cell_rden      (cell_rden),
        .cell_wren      (cell_wren),
        .cell_data      (cell_data),
        .cell_q         (cell_q),
        .stream         (sif)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (cell_rden) rd1 <= mem[cell_address];
        cell_q <= rd1;
    end
    task automatic check(string tag, logic [127:0] got, logic [127:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    function automatic logic [DW-1:0] pword(int seed, int a);
        return {32'(seed * 7 + a), 32'(a * 13 + seed), 32'(32'hC0DE_0000 | a)};
    endfunction
    always @(negedge clk) begin
        #2;
        if (!rst) outst = 0;
        else begin
            if (done) done_cnt++;
            if (cell_rden && cell_address != 0) outst++;
            if (outst > max_outst) max_outst = outst;
            if (sif.valid && sif.ready) begin
                outst--;
                last_id = int'(sif.id);
                if (sb.size() == 0) check("spurious_out", {sif.valid, sif.id}, 0);
                else begin
                    e = sb.pop_front();
                    check("out_id", sif.id, e.id);
                    check("out_data", sif.data, e.data);
                    check("out_last", sif.last, e.last);
                end
            end
        end
    end
    task automatic tick(int n);
        repeat (n) @(negedge clk);
    endtask
    function automatic int exp_count(int raw);
`ifdef CELL_READER_BOUNDS_CHECK_EN
        return raw > PN - 1 ? PN - 1 : raw;
`else
        return raw;
`endif
    endfunction
    task automatic launch(int raw, int seed);
        int n = exp_count(raw);
        mem[0] = {88'h5A_A5C3_3CF0_0F96_6996_1234, 8'(raw)};
        for (int a = 1; a <= raw; a++) mem[a] = pword(seed, a);
        for (int a = 1; a <= n; a++) sb.push_back('{id: AW'(a), data: pword(seed, a), last: a == n});
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask
    task automatic wait_done();
        int i = 0;
        while (!done && i < 3000) begin
            tick(1);
            i++;
        end
        check("done_seen", done, 1);
        tick(2);
    endtask
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        sif.ready = 1'b1;
        tick(3);
        check("rst_ctrl", {busy, done, cell_rden, sif.valid, sif.last, count_err}, 0);
        check("rst_regs", {particle_count, cell_address, sif.id}, 0);
        rst = 1'b1;
        tick(2);
        launch(3, 11);
        check("t1_rd_count", {cell_rden, cell_address}, {1'b1, 8'd0});
        check("t1_busy", busy, 1);
        tick(1);
        check("t2_rden_low", cell_rden, 0);
        tick(2);
        check("t4_rd_addr1", {cell_rden, cell_address}, {1'b1, 8'd1});
        tick(2);
        check("t6_rd_addr3", {cell_rden, cell_address}, {1'b1, 8'd3});
        tick(1);
        check("t7_valid_id1", {sif.valid, sif.id}, {1'b1, 8'd1});
        tick(2);
        check("t9_last_id3", {sif.valid, sif.last, sif.id}, {1'b1, 1'b1, 8'd3});
        tick(1);
        check("t10_done", done, 1);
        check("c3_count", particle_count, 3);
        tick(2);
        check("c3_done_total", done_cnt, 1);
        check("c3_sb_empty", sb.size(), 0);
        launch(0, 22);
        tick(2);
        check("c0_t3_no_done", done, 0);
        tick(1);
        check("c0_t4_done", done, 1);
        check("c0_count", particle_count, 0);
        tick(2);
        check("c0_done_total", done_cnt, 2);
        check("c0_idle", busy, 0);
        max_outst = 0;
        launch(10, 33);
        tick(6);
        sif.ready = 1'b0;
        tick(5);
        check("stall_rden", cell_rden, 0);
        check("stall_hold", {sif.valid, sif.id, sif.data}, {1'b1, 8'd1, pword(33, 1)});
        tick(1);
        sif.ready = 1'b1;
        wait_done();
        check("stall_max_outst", max_outst <= FD, 1);
        check("stall_sb_empty", sb.size(), 0);
        check("stall_done_total", done_cnt, 3);
        launch(10, 44);
        tick(7);
        rst = 1'b0;
        tick(1);
        check("mid_rst_ctrl", {busy, done, cell_rden, sif.valid, sif.last, count_err}, 0);
        check("mid_rst_regs", {particle_count, cell_address, sif.id}, 0);
        check("mid_rst_data", sif.data, 0);
        rst = 1'b1;
        sb.delete();
        tick(2);
        check("mid_rst_no_done", done_cnt, 3);
        launch(10, 55);
        wait_done();
        check("restart_sb_empty", sb.size(), 0);
        check("restart_last_id", last_id, 10);
        check("restart_done_total", done_cnt, 4);
        launch(250, 66);
        wait_done();
        check("bounds_count", particle_count, exp_count(250));
        check("bounds_err", count_err, exp_count(250) != 250);
        check("bounds_last_id", last_id, exp_count(250));
        check("bounds_sb_empty", sb.size(), 0);
        launch(3, 77);
        check("err_cleared", count_err, 0);
        tick(4);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done();
        tick(10);
        check("restart_ignored_done", done_cnt, 6);
        check("restart_ignored_sb", sb.size(), 0);
        check("restart_ignored_idle", busy, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cell_stream_reader.md
Name: cell_stream_reader

Overview:
- Read-side controller for one per-cell position memory: single-port, 2-cycle read latency, address 0 holds the particle count, addresses 1..N hold {posz, posy, posx}.
- On start, fetches the count, then streams every particle word out over a valid/ready interface.
- Sits between a cell memory instance and the force-evaluation pair-generation front end; absorbs downstream backpressure without losing in-flight RAM reads.

Parameters:
- DATA_WIDTH, 96, width of one memory word {posz,posy,posx}, 3x32-bit float
- ADDR_WIDTH, 8, cell memory address width
- PARTICLE_NUM, 220, memory depth; max particle count is PARTICLE_NUM-1
- FIFO_DEPTH, 4, output buffer depth (power of 2, >=3)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to stream the cell; sampled only in IDLE
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last particle handshake (or after count fetch if count=0)
- particle_count  out  ADDR_WIDTH  count latched from address 0
- count_err  out  1  count exceeded PARTICLE_NUM-1 (feature only; else tied 0)
- cell_address  out  ADDR_WIDTH  to memory address
- cell_rden  out  1  to memory rden
- cell_wren  out  1  tied 0
- cell_data  out  DATA_WIDTH  tied 0
- cell_q  in  DATA_WIDTH  memory read data
- out_data  out  DATA_WIDTH  particle position
- out_id  out  ADDR_WIDTH  memory address of out_data (1..N)
- out_last  out  1  marks particle N
- out_valid  out  1  data valid
- out_ready  in  1  consumer accepts

Behaviour:
- Reset (rst=0 at a clk edge): state IDLE; busy, done, cell_rden, out_valid, out_last, count_err = 0; cell_address, particle_count, out_id, out_data = 0; FIFO and in-flight tracker cleared. Memory data returning after reset is discarded. Reset mid-stream aborts with no done pulse.
- All memory-side outputs are registered.
- FSM states:
  - IDLE: start=1 -> RD_CNT.
  - RD_CNT: cell_address=0, cell_rden=1 for exactly one cycle -> WAIT_CNT.
  - WAIT_CNT: 2 cycles; on the 2nd, latch particle_count = cell_q[ADDR_WIDTH-1:0]. count=0 -> DONE, else -> STREAM with next_addr=1.
  - STREAM: issue read of next_addr (rden=1) when credit is available; after issuing address N -> DRAIN.
  - DRAIN: wait until in-flight tracker and FIFO are empty and the last handshake occurs -> DONE.
  - DONE: done=1 for one cycle -> IDLE.
- Timing: start sampled at end of cycle t -> rden/addr 0 in t+1 -> count valid in t+3 -> addr 1 issued in t+4 -> data into FIFO end of t+6 -> out_valid in t+7.
- Credit rule: issue a read only when (reads in 2-stage in-flight shift register) + FIFO occupancy < FIFO_DEPTH. The FIFO therefore never overflows. With out_ready held high, throughput is 1 particle/cycle.
- In-flight tracker: 2-stage shift register of {valid, addr, last}. Its output pushes {cell_q, addr, last} into the FIFO.
- Output is a standard valid/ready interface: data held stable while out_valid and not out_ready; handshake = out_valid && out_ready. The FIFO supports simultaneous push and pop at full occupancy.
- start while busy is ignored. out_id increments strictly 1..N with no gaps or duplicates.

Optional Feature:
- Macro CELL_READER_BOUNDS_CHECK_EN.
- Defined: if the latched count > PARTICLE_NUM-1, particle_count is clamped to PARTICLE_NUM-1 and count_err=1 (held until the next start or reset); streaming uses the clamped value.
- Undefined: the raw count is used unchecked; count_err is constant 0.

Decomposition:
- Shared package/define header: FSM state encoding constants, CELL_COUNT_ADDR = 0, FIRST_PARTICLE_ADDR = 1, read latency constant CELL_RD_LATENCY = 2 (sizes the tracker).
- One sub-module: cell_rd_fifo, a synchronous FIFO of width DATA_WIDTH+ADDR_WIDTH+1 and depth FIFO_DEPTH, exporting an occupancy count for the credit logic.

Test Plan:
- Count=3, out_ready=1, start at t: rden at t+1 (addr 0) and t+4..t+6 (addr 1,2,3); out_valid t+7..t+9 with out_id 1,2,3; out_last at t+9; done at t+10.
- Count=0: no out_valid ever; done pulses at t+4; particle_count=0.
- Count=10, out_ready low for 6 cycles starting at t+7: at most 4 reads outstanding, rden stalls; after release all 10 ids delivered in order with matching data and no loss.
- rst=0 asserted at t+8 of a count-10 stream: next cycle all outputs 0 and state IDLE; a new start then streams all 10 from id 1 correctly.
- With CELL_READER_BOUNDS_CHECK_EN and stored count 250 (PARTICLE_NUM=220): particle_count=219, count_err=1, last out_id=219. Without the macro: count_err=0.
- Pulse start again at t+5 during a count-3 stream: ignored; exactly one done, 3 particles delivered.
